// File: rtl/hello_scroll_ctrl_if.sv
// rtl/hello_scroll_ctrl_if.sv - enable input and display/scroll outputs of the HELLO scroller
interface hello_scroll_ctrl_if;
    logic       en;
    logic [7:0] y;
    logic [3:0] an;
    logic [2:0] c;
    logic       step;

    // Controller side: takes the run enable, drives the pins and scroll status
    modport slave  (input en, output y, output an, output c, output step);
    // Board/bench side: drives the run enable, watches the pins
    modport master (output en, input y, input an, input c, input step);
endinterface

// File: rtl/hello_scroll_ctrl.sv
// rtl/hello_scroll_ctrl.sv - four-digit multiplexed 7-segment scroller for "HELLO"
module hello_scroll_ctrl #(
    parameter int SCAN_DIV    = 4,
    parameter int SHIFT_TICKS = 2
) (
    input  logic                ck,
    input  logic                rs,
    hello_scroll_ctrl_if.slave  bus
);
    localparam int SC_W = $clog2(SCAN_DIV);
    localparam int FR_W = (SHIFT_TICKS > 1) ? $clog2(SHIFT_TICKS) : 1;
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(SCAN_DIV - 1);
    localparam logic [FR_W-1:0] FR_MAX = FR_W'(SHIFT_TICKS - 1);

    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [SC_W-1:0] sc_q, sc_d;
    logic [1:0]      dig_q, dig_d;
    logic [FR_W-1:0] fr_q, fr_d;
    logic [2:0]      pos_q, pos_d;
    logic [7:0]      y_q, y_d;
    logic [3:0]      an_q, an_d;
    logic            step_q, step_d;
    logic            run;
    logic [2:0]      msg_idx;

    // Message ROM: HELLO followed by three blanks so the text scrolls off before repeating
    function automatic logic [7:0] msg_rom(input logic [2:0] idx);
        case (idx)
            3'd0:    msg_rom = 8'h89;
            3'd1:    msg_rom = 8'h86;
            3'd2:    msg_rom = 8'hC7;
            3'd3:    msg_rom = 8'hC7;
            3'd4:    msg_rom = 8'hC0;
            default: msg_rom = 8'hFF;
        endcase
    endfunction

    // Next-state for the FSM, the scan/frame/scroll counter chain and the output registers
    always_comb begin
        state_d = bus.en ? SCAN : IDLE;
        sc_d    = sc_q;
        dig_d   = dig_q;
        fr_d    = fr_q;
        pos_d   = pos_q;
        step_d  = 1'b0;
        run     = (state_q == SCAN);
        msg_idx = pos_q + {1'b0, dig_q};

        if (run) begin
            sc_d = (sc_q == SC_MAX) ? '0 : sc_q + 1'b1;
            if (sc_q == SC_MAX) begin
                dig_d = dig_q + 2'd1;
                if (dig_q == 2'd3) begin
                    fr_d = (fr_q == FR_MAX) ? '0 : fr_q + 1'b1;
                    if (fr_q == FR_MAX) begin
                        pos_d  = pos_q + 3'd1;
                        step_d = 1'b1;
                    end
                end
            end
        end

        // Slot phase 0 keeps every anode off so the previous digit's segments never ghost
        y_d  = run ? msg_rom(msg_idx) : 8'hFF;
        an_d = (run && (sc_q != '0)) ? ~(4'b0001 << dig_q) : 4'b1111;
    end

    // Single register stage for FSM, counters and all pin outputs; reset wins over everything
    always_ff @(posedge ck) begin
        if (rs) begin
            state_q <= IDLE;
            sc_q    <= '0;
            dig_q   <= '0;
            fr_q    <= '0;
            pos_q   <= '0;
            y_q     <= 8'hFF;
            an_q    <= 4'b1111;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sc_q    <= sc_d;
            dig_q   <= dig_d;
            fr_q    <= fr_d;
            pos_q   <= pos_d;
            y_q     <= y_d;
            an_q    <= an_d;
            step_q  <= step_d;
        end
    end

    assign bus.y    = y_q;
    assign bus.an   = an_q;
    assign bus.c    = pos_q;
    assign bus.step = step_q;
endmodule
